// File: rtl/db_req.sv
// db_req: SRIO initiator sequencer. Sends a self-check doorbell, one NWRITE, then a data-integration doorbell.
// Defining DB_REQ_STAT_EN enables the cumulative payload byte counter on tx_byte_cnt_o.
module db_req #(
  parameter int TIMEOUT_CYC = 4096,
  parameter int MAX_RETRY   = 4,
  parameter int RETRY_GAP   = 64
) (
  input  logic        log_clk,
  input  logic        log_rst_n,
  input  logic [15:0] src_id,
  input  logic [15:0] des_id,
  input  logic        start_in,
  input  logic        last_in,
  input  logic [7:0]  nwr_size_in,
  input  logic [33:0] nwr_addr_in,
  input  logic        data_tvalid_in,
  output logic        data_tready_o,
  input  logic [63:0] data_tdata_in,
  input  logic        ireq_tready_in,
  output logic        ireq_tvalid_o,
  output logic        ireq_tlast_o,
  output logic [63:0] ireq_tdata_o,
  output logic [7:0]  ireq_tkeep_o,
  output logic [31:0] ireq_tuser_o,
  input  logic        iresp_tvalid_in,
  output logic        iresp_tready_o,
  input  logic [63:0] iresp_tdata_in,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] tx_byte_cnt_o
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] SELF_DB   = 4'd1;
  localparam logic [3:0] WAIT_RDY  = 4'd2;
  localparam logic [3:0] GAP       = 4'd3;
  localparam logic [3:0] NWR_HDR   = 4'd4;
  localparam logic [3:0] NWR_DATA  = 4'd5;
  localparam logic [3:0] DATA_DB   = 4'd6;
  localparam logic [3:0] WAIT_ECHO = 4'd7;
  localparam logic [3:0] DONE      = 4'd8;
  localparam logic [3:0] ERR       = 4'd9;

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT_CYC);
  localparam logic [15:0] GAP_W     = 16'(RETRY_GAP);
  localparam logic [7:0]  RETRY_W   = 8'(MAX_RETRY);

  localparam logic [15:0] INFO_SELF  = 16'h0101;
  localparam logic [15:0] INFO_READY = 16'h0100;
  localparam logic [15:0] INFO_NRDY  = 16'h01FF;

  logic [3:0]  r_state;
  logic [7:0]  r_tid;
  logic [7:0]  r_size;
  logic [33:0] r_addr;
  logic        r_last;
  logic [7:0]  r_retry;
  logic [15:0] r_timer;
  logic [15:0] r_gap;
  logic [4:0]  r_beat;

  logic        w_ireqHs;
  logic        w_lastBeat;
  logic [7:0]  w_lastKeep;
  logic        w_dbResp;
  logic [15:0] w_respInfo;
  logic [15:0] w_dataInfo;
  logic [63:0] w_hdrBeat;
  logic        w_timedOut;
  logic [7:0]  w_retryNext;
  logic        w_unused;

  function automatic logic [63:0] dbBeat(input logic [7:0] tid, input logic [15:0] info);
    return {tid, 4'hA, 4'h0, 1'b0, 2'h1, 1'b0, 12'h0, info, 16'h0};
  endfunction

  assign w_ireqHs    = ireq_tvalid_o && ireq_tready_in;
  assign w_lastBeat  = (r_beat == r_size[7:3]);
  assign w_lastKeep  = 8'hff << (3'd7 - r_size[2:0]);
  assign w_dbResp    = iresp_tvalid_in && (iresp_tdata_in[55:52] == 4'hA);
  assign w_respInfo  = iresp_tdata_in[31:16];
  assign w_dataInfo  = r_last ? 16'h0201 : 16'h0200;
  assign w_hdrBeat   = {r_tid, 4'h5, 4'h4, 1'b0, 2'h1, 1'b0, r_size, 2'b00, r_addr};
  assign w_timedOut  = (r_timer >= TIMEOUT_W);
  assign w_retryNext = r_retry + 8'd1;
  assign w_unused    = &{1'b0, iresp_tdata_in[63:56], iresp_tdata_in[51:32], iresp_tdata_in[15:0]};

  assign iresp_tready_o = 1'b1;
  assign ireq_tuser_o   = ireq_tvalid_o ? {src_id, des_id} : 32'd0;
  assign busy_o         = (r_state != IDLE) && (r_state != DONE) && (r_state != ERR);
  assign done_o         = (r_state == DONE);
  assign err_o          = (r_state == ERR);

  always_ff @(posedge log_clk or negedge log_rst_n) begin
    if (!log_rst_n) begin
      r_state <= IDLE;
      r_tid   <= 8'd0;
      r_size  <= 8'd0;
      r_addr  <= 34'd0;
      r_last  <= 1'b0;
      r_retry <= 8'd0;
      r_timer <= 16'd0;
      r_gap   <= 16'd0;
      r_beat  <= 5'd0;
    end else begin
      if (w_ireqHs && ireq_tlast_o) r_tid <= r_tid + 8'd1;
      case (r_state)
        IDLE: begin
          if (start_in) begin
            r_size  <= nwr_size_in;
            r_addr  <= nwr_addr_in;
            r_last  <= last_in;
            r_retry <= 8'd0;
            r_state <= SELF_DB;
          end
        end
        SELF_DB: begin
          if (ireq_tready_in) begin
            r_timer <= 16'd0;
            r_state <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          // Any other response (or other doorbell info) just lets the timer keep running.
          if (w_dbResp && w_respInfo == INFO_READY) begin
            r_state <= NWR_HDR;
          end else if (w_dbResp && w_respInfo == INFO_NRDY) begin
            r_retry <= w_retryNext;
            r_gap   <= 16'd0;
            r_state <= (w_retryNext == RETRY_W) ? ERR : GAP;
          end else if (w_timedOut) begin
            r_state <= ERR;
          end else if (r_timer != 16'hffff) begin
            r_timer <= r_timer + 16'd1;
          end
        end
        GAP: begin
          if (r_gap >= GAP_W - 16'd1) r_state <= SELF_DB;
          else r_gap <= r_gap + 16'd1;
        end
        NWR_HDR: begin
          if (ireq_tready_in) begin
            r_beat  <= 5'd0;
            r_state <= NWR_DATA;
          end
        end
        NWR_DATA: begin
          if (w_ireqHs) begin
            if (w_lastBeat) r_state <= DATA_DB;
            else r_beat <= r_beat + 5'd1;
          end
        end
        DATA_DB: begin
          if (ireq_tready_in) begin
            r_timer <= 16'd0;
            r_state <= WAIT_ECHO;
          end
        end
        WAIT_ECHO: begin
          if (w_dbResp) begin
            r_state <= (w_respInfo == w_dataInfo) ? DONE : ERR;
          end else if (w_timedOut) begin
            r_state <= ERR;
          end else if (r_timer != 16'hffff) begin
            r_timer <= r_timer + 16'd1;
          end
        end
        DONE, ERR: begin
          r_retry <= 8'd0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Payload beats bypass any register so the user stream sees the core's backpressure directly.
  always_comb begin
    ireq_tvalid_o = 1'b0;
    ireq_tlast_o  = 1'b0;
    ireq_tdata_o  = 64'd0;
    ireq_tkeep_o  = 8'd0;
    data_tready_o = 1'b0;
    case (r_state)
      SELF_DB: begin
        ireq_tvalid_o = 1'b1;
        ireq_tlast_o  = 1'b1;
        ireq_tdata_o  = dbBeat(r_tid, INFO_SELF);
        ireq_tkeep_o  = 8'hff;
      end
      NWR_HDR: begin
        ireq_tvalid_o = 1'b1;
        ireq_tdata_o  = w_hdrBeat;
        ireq_tkeep_o  = 8'hff;
      end
      NWR_DATA: begin
        ireq_tvalid_o = data_tvalid_in;
        data_tready_o = ireq_tready_in;
        ireq_tdata_o  = data_tdata_in;
        ireq_tkeep_o  = w_lastBeat ? w_lastKeep : 8'hff;
        ireq_tlast_o  = w_lastBeat;
      end
      DATA_DB: begin
        ireq_tvalid_o = 1'b1;
        ireq_tlast_o  = 1'b1;
        ireq_tdata_o  = dbBeat(r_tid, w_dataInfo);
        ireq_tkeep_o  = 8'hff;
      end
      default: ;
    endcase
  end

`ifdef DB_REQ_STAT_EN
  logic [31:0] r_txByteCnt;

  always_ff @(posedge log_clk or negedge log_rst_n) begin
    if (!log_rst_n) begin
      r_txByteCnt <= 32'd0;
    end else if (r_state == NWR_DATA && w_ireqHs && w_lastBeat) begin
      r_txByteCnt <= r_txByteCnt + {24'd0, r_size} + 32'd1;
    end
  end

  assign tx_byte_cnt_o = r_txByteCnt;
`else
  assign tx_byte_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_db_req.sv
// tb_db_req: scoreboard bench for db_req with a scripted doorbell responder and a stallable payload source.
// Expected beats and outcomes are queued at stimulus time and popped by an independent monitor.
module tb_db_req;

  localparam int TIMEOUT_CYC = 4096;
  localparam int MAX_RETRY   = 4;
  localparam int RETRY_GAP   = 64;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  logic        log_clk;
  logic        log_rst_n;
  logic [15:0] src_id;
  logic [15:0] des_id;
  logic        start_in;
  logic        last_in;
  logic [7:0]  nwr_size_in;
  logic [33:0] nwr_addr_in;
  logic        data_tvalid_in;
  logic        data_tready_o;
  logic [63:0] data_tdata_in;
  logic        ireq_tready_in;
  logic        ireq_tvalid_o;
  logic        ireq_tlast_o;
  logic [63:0] ireq_tdata_o;
  logic [7:0]  ireq_tkeep_o;
  logic [31:0] ireq_tuser_o;
  logic        iresp_tvalid_in;
  logic        iresp_tready_o;
  logic [63:0] iresp_tdata_in;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] tx_byte_cnt_o;

  beat_t       expQ[$];
  logic        expOutQ[$];
  logic [63:0] payQ[$];
  logic [16:0] replyQ[$];

  int          total = 0;
  int          bad = 0;
  logic [7:0]  expTid = 8'd0;
  logic [31:0] byteModel = 32'd0;
  int          readyMode = 0;
  bit          stallMode = 1'b0;

  db_req #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .MAX_RETRY  (MAX_RETRY),
    .RETRY_GAP  (RETRY_GAP)
  ) dut (
    .log_clk        (log_clk),
    .log_rst_n      (log_rst_n),
    .src_id         (src_id),
    .des_id         (des_id),
    .start_in       (start_in),
    .last_in        (last_in),
    .nwr_size_in    (nwr_size_in),
    .nwr_addr_in    (nwr_addr_in),
    .data_tvalid_in (data_tvalid_in),
    .data_tready_o  (data_tready_o),
    .data_tdata_in  (data_tdata_in),
    .ireq_tready_in (ireq_tready_in),
    .ireq_tvalid_o  (ireq_tvalid_o),
    .ireq_tlast_o   (ireq_tlast_o),
    .ireq_tdata_o   (ireq_tdata_o),
    .ireq_tkeep_o   (ireq_tkeep_o),
    .ireq_tuser_o   (ireq_tuser_o),
    .iresp_tvalid_in(iresp_tvalid_in),
    .iresp_tready_o (iresp_tready_o),
    .iresp_tdata_in (iresp_tdata_in),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .tx_byte_cnt_o  (tx_byte_cnt_o)
  );

  initial begin
    log_clk = 1'b0;
    forever #5 log_clk = ~log_clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic pushDb(input logic [15:0] info);
    beat_t b;
    b.data = {expTid, 4'hA, 4'h0, 1'b0, 2'h1, 1'b0, 12'h0, info, 16'h0};
    b.keep = 8'hff;
    b.last = 1'b1;
    expQ.push_back(b);
    expTid = expTid + 8'd1;
  endtask

  // Driver: owns every DUT input except reset/start/config; all updates land 1 time unit after posedge.
  initial begin
    int          cycle;
    int          replyDelay;
    logic [15:0] replyInfo;
    logic [16:0] r;
    bit          sIreqHs;
    bit          sDataHs;
    cycle = 0;
    replyDelay = 0;
    replyInfo = 16'h0;
    ireq_tready_in = 1'b0;
    iresp_tvalid_in = 1'b0;
    iresp_tdata_in = 64'd0;
    data_tvalid_in = 1'b0;
    data_tdata_in = 64'd0;
    forever begin
      @(negedge log_clk);
      sIreqHs = ireq_tvalid_o && ireq_tready_in;
      sDataHs = data_tvalid_in && data_tready_o;
      if (sIreqHs && ireq_tlast_o && ireq_tdata_o[55:52] == 4'hA && replyQ.size() > 0) begin
        r = replyQ.pop_front();
        if (r[16]) begin
          replyDelay = 3;
          replyInfo = r[15:0];
        end
      end
      @(posedge log_clk);
      #1;
      cycle++;
      if (sDataHs && payQ.size() > 0) void'(payQ.pop_front());
      iresp_tvalid_in = 1'b0;
      iresp_tdata_in = 64'd0;
      if (replyDelay == 1) begin
        iresp_tvalid_in = 1'b1;
        iresp_tdata_in = {8'h00, 4'hA, 4'h0, 16'h0, replyInfo, 16'h0};
      end
      if (replyDelay > 0) replyDelay--;
      case (readyMode)
        1: ireq_tready_in = (cycle % 2 == 0);
        2: ireq_tready_in = 1'b0;
        default: ireq_tready_in = 1'b1;
      endcase
      data_tvalid_in = (payQ.size() > 0) && !(stallMode && (cycle % 3 == 0));
      data_tdata_in = (payQ.size() > 0) ? payQ[0] : 64'd0;
    end
  end

  // Monitor: pops the scoreboard on every request handshake and on every done/err pulse.
  initial begin
    beat_t       e;
    logic        o;
    int          monCycle;
    int          lastSelf;
    bit          prevStall;
    logic [63:0] prevData;
    monCycle = 0;
    lastSelf = -1;
    prevStall = 1'b0;
    prevData = 64'd0;
    forever begin
      @(negedge log_clk);
      monCycle++;
      if (!log_rst_n) begin
        prevStall = 1'b0;
      end else begin
        if (prevStall && ireq_tvalid_o) checkOutput("stall_hold", ireq_tdata_o, prevData);
        prevStall = ireq_tvalid_o && !ireq_tready_in;
        prevData = ireq_tdata_o;
        if (ireq_tvalid_o && ireq_tready_in) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_beat", ireq_tdata_o, 64'd0);
          end else begin
            e = expQ.pop_front();
            checkOutput("beat_data", ireq_tdata_o, e.data);
            checkOutput("beat_keep", {56'd0, ireq_tkeep_o}, {56'd0, e.keep});
            checkOutput("beat_last", {63'd0, ireq_tlast_o}, {63'd0, e.last});
            checkOutput("beat_tuser", {32'd0, ireq_tuser_o}, {32'd0, src_id, des_id});
          end
          if (ireq_tdata_o[55:52] == 4'hA && ireq_tdata_o[31:16] == 16'h0101) begin
            if (lastSelf >= 0)
              checkOutput("retry_gap_ok", 64'((monCycle - lastSelf) >= RETRY_GAP), 64'd1);
            lastSelf = monCycle;
          end else begin
            lastSelf = -1;
          end
        end
        if (done_o || err_o) begin
          lastSelf = -1;
          if (expOutQ.size() == 0) begin
            checkOutput("unexpected_outcome", {62'd0, done_o, err_o}, 64'd0);
          end else begin
            o = expOutQ.pop_front();
            checkOutput("outcome_done", {63'd0, done_o}, {63'd0, o});
            checkOutput("outcome_err", {63'd0, err_o}, {63'd0, !o});
          end
        end
      end
    end
  end

  task automatic checkBytes();
    logic [31:0] expBytes;
`ifdef DB_REQ_STAT_EN
    expBytes = byteModel;
`else
    expBytes = 32'd0;
`endif
    checkOutput("tx_byte_cnt", {32'd0, tx_byte_cnt_o}, {32'd0, expBytes});
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (expOutQ.size() != 0 && n < 8000) begin
      @(posedge log_clk);
      n++;
    end
    if (expOutQ.size() != 0) begin
      checkOutput("completion_pending", 64'(expOutQ.size()), 64'd0);
      expOutQ.delete();
      expQ.delete();
      payQ.delete();
      replyQ.delete();
    end
    repeat (4) @(posedge log_clk);
    #1;
    checkOutput("leftover_beats", 64'(expQ.size()), 64'd0);
    checkOutput("leftover_payload", 64'(payQ.size()), 64'd0);
    checkOutput("busy_after", {63'd0, busy_o}, 64'd0);
    checkBytes();
  endtask

  task automatic applyStimulus(input int tnum, input logic [7:0] size, input logic [33:0] addr,
                               input logic last, input int nNotReady, input bit silent,
                               input bit wrongEcho, input bit extraStart);
    beat_t       b;
    int          sz;
    int          nBeats;
    int          k;
    logic [15:0] info;
    logic [63:0] d;
    sz = int'(size);
    if (silent) begin
      pushDb(16'h0101);
      replyQ.push_back({1'b0, 16'h0});
      expOutQ.push_back(1'b0);
    end else if (nNotReady >= MAX_RETRY) begin
      for (int i = 0; i < MAX_RETRY; i++) begin
        pushDb(16'h0101);
        replyQ.push_back({1'b1, 16'h01FF});
      end
      expOutQ.push_back(1'b0);
    end else begin
      for (int i = 0; i < nNotReady; i++) begin
        pushDb(16'h0101);
        replyQ.push_back({1'b1, 16'h01FF});
      end
      pushDb(16'h0101);
      replyQ.push_back({1'b1, 16'h0100});
      b.data = {expTid, 4'h5, 4'h4, 1'b0, 2'h1, 1'b0, size, 2'b00, addr};
      b.keep = 8'hff;
      b.last = 1'b0;
      expQ.push_back(b);
      nBeats = sz / 8 + 1;
      k = sz % 8 + 1;
      for (int i = 0; i < nBeats; i++) begin
        d = {8'(tnum), 8'(i), 16'hBEEF, addr[31:0] + 32'(i)};
        payQ.push_back(d);
        b.data = d;
        b.last = (i == nBeats - 1);
        b.keep = 8'hff;
        if (b.last) begin
          b.keep = 8'h00;
          for (int j = 0; j < k; j++) b.keep[7 - j] = 1'b1;
        end
        expQ.push_back(b);
      end
      expTid = expTid + 8'd1;
      info = last ? 16'h0201 : 16'h0200;
      pushDb(info);
      if (wrongEcho) replyQ.push_back({1'b1, (info == 16'h0200) ? 16'h0201 : 16'h0200});
      else replyQ.push_back({1'b1, info});
      byteModel = byteModel + 32'(sz + 1);
      expOutQ.push_back(!wrongEcho);
    end
    @(posedge log_clk);
    #1;
    nwr_size_in = size;
    nwr_addr_in = addr;
    last_in = last;
    start_in = 1'b1;
    @(posedge log_clk);
    #1;
    start_in = 1'b0;
    nwr_size_in = 8'hAA;
    nwr_addr_in = 34'h3_FFFF_0000;
    checkOutput("busy_after_start", {63'd0, busy_o}, 64'd1);
    if (extraStart) begin
      repeat (4) @(posedge log_clk);
      #1;
      start_in = 1'b1;
      @(posedge log_clk);
      #1;
      start_in = 1'b0;
    end
    waitDone();
  endtask

  initial begin
    log_rst_n = 1'b0;
    src_id = 16'h1234;
    des_id = 16'h5678;
    start_in = 1'b0;
    last_in = 1'b0;
    nwr_size_in = 8'd0;
    nwr_addr_in = 34'd0;
    repeat (3) @(posedge log_clk);
    #1;
    checkOutput("rst_tvalid", {63'd0, ireq_tvalid_o}, 64'd0);
    checkOutput("rst_tdata", ireq_tdata_o, 64'd0);
    checkOutput("rst_tkeep_tlast", {55'd0, ireq_tkeep_o, ireq_tlast_o}, 64'd0);
    checkOutput("rst_tuser", {32'd0, ireq_tuser_o}, 64'd0);
    checkOutput("rst_iresp_tready", {63'd0, iresp_tready_o}, 64'd1);
    checkOutput("rst_flags", {60'd0, busy_o, done_o, err_o, data_tready_o}, 64'd0);
    checkOutput("rst_bytes", {32'd0, tx_byte_cnt_o}, 64'd0);
    @(negedge log_clk);
    log_rst_n = 1'b1;
    repeat (2) @(posedge log_clk);

    $display("[TB] basic transfer size=15, extra start while busy");
    applyStimulus(1, 8'd15, 34'h100, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    $display("[TB] size=4 last transfer");
    applyStimulus(2, 8'd4, 34'h3_0000_0008, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    $display("[TB] two not-ready replies then ready, size=0");
    applyStimulus(3, 8'd0, 34'h0_0000_2000, 1'b0, 2, 1'b0, 1'b0, 1'b0);
    $display("[TB] not-ready until retry limit");
    applyStimulus(4, 8'd15, 34'h0_0000_3000, 1'b0, MAX_RETRY, 1'b0, 1'b0, 1'b0);
    $display("[TB] ready timeout");
    applyStimulus(5, 8'd15, 34'h0_0000_4000, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    $display("[TB] mismatching echo");
    applyStimulus(6, 8'd15, 34'h0_0000_5000, 1'b0, 0, 1'b0, 1'b1, 1'b0);

    readyMode = 1;
    stallMode = 1'b1;
    $display("[TB] stalled transfer size=255");
    applyStimulus(7, 8'd255, 34'h1_0000_0000, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    $display("[TB] stalled transfer size=15");
    applyStimulus(8, 8'd15, 34'h0_0000_6000, 1'b1, 1, 1'b0, 1'b0, 1'b0);

    $display("[TB] reset while doorbell is stalled");
    stallMode = 1'b0;
    readyMode = 2;
    replyQ.push_back({1'b1, 16'h0100});
    @(posedge log_clk);
    #1;
    nwr_size_in = 8'd7;
    nwr_addr_in = 34'h0_0000_7000;
    start_in = 1'b1;
    @(posedge log_clk);
    #1;
    start_in = 1'b0;
    repeat (3) @(posedge log_clk);
    #1;
    checkOutput("tvalid_before_reset", {63'd0, ireq_tvalid_o}, 64'd1);
    log_rst_n = 1'b0;
    #1;
    checkOutput("tvalid_after_reset", {63'd0, ireq_tvalid_o}, 64'd0);
    checkOutput("busy_after_reset", {63'd0, busy_o}, 64'd0);
    checkOutput("bytes_after_reset", {32'd0, tx_byte_cnt_o}, 64'd0);
    replyQ.delete();
    repeat (2) @(posedge log_clk);
    readyMode = 0;
    @(negedge log_clk);
    log_rst_n = 1'b1;
    repeat (2) @(posedge log_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
